tqvp_alu_cmd_queue: RTL and testbench
=====================================

Name: tqvp_alu_cmd_queue

Overview:
- Register-mapped TinyQV peripheral that sits directly upstream of the 4-op 8-bit ALU and feeds it.
- The CPU stages operand A and operand B, then writes an opcode. This pushes an {A,B,op} command into a command FIFO.
- An issue stage drains one command per cycle through the ALU core and pushes each 8-bit result into a result FIFO, which the CPU peeks and pops.
- Lets software queue batches of ALU operations without polling between them.

Parameters:
- DEPTH, 4, entries in each FIFO; power of 2, minimum 2.
- CW, 3, count width; equals log2(DEPTH)+1.

Ports:
- clk  in  1  peripheral clock (64 MHz nominal).
- rst_n  in  1  reset; asynchronous, active-low.
- ui_in  in  8  input PMOD; unused.
- uo_out  out  8  output PMOD; tied to 8'h00.
- address  in  4  register address.
- data_write  in  1  write strobe, single cycle.
- data_in  in  8  write data, valid with data_write.
- data_out  out  8  read data, combinational from address.

Behaviour:
- Reset (async assert, release on the next clk edge): A=0, B=0, both FIFOs empty (pointers and counts 0), sticky flags 0, data_out follows address per the map with those values.
- Register map, write side (action taken on the clk edge with data_write=1):
  - 0x0 writes A.
  - 0x1 writes B.
  - 0x2 pushes {A, B, data_in[1:0]}. data_in[7:2] is ignored. A and B are sampled as they stood before this edge.
  - 0x3 pops the result FIFO; data is ignored.
  - 0x4 clears the overflow and underflow sticky flags.
  - 0x5–0xF are ignored.
- Register map, read side (combinational):
  - 0x0 returns A; 0x1 returns B.
  - 0x2 returns {6'b0, op at cmd FIFO head}; returns 0 when the cmd FIFO is empty.
  - 0x3 returns the result FIFO head; returns 0 when empty.
  - 0x4 returns status: bit0 cmd_empty, bit1 cmd_full, bit2 res_empty, bit3 res_full, bit4 overflow, bit5 underflow, bits 7:6 = 0.
  - 0x5 returns {1'b0, cmd_count[2:0], 1'b0, res_count[2:0]}.
  - 0x6–0xF return 8'h00.
- ALU ops (mod 256, no flags):
  - 00: A+B.
  - 01: A−B, two's-complement wrap.
  - 10: A&B.
  - 11: A|B.
- Issue rule: issue = !cmd_empty && (!res_full || pop_this_cycle). On an issuing edge the cmd head is popped, the ALU result of the head is pushed to the result FIFO, and both counts update together.
- Cmd push rule: push_ok = !cmd_full || issue. A push to 0x2 when push_ok=0 drops the command and sets overflow. The cmd FIFO is unchanged.
- Pop rule: a pop when res_empty=1 sets underflow. FIFO state is unchanged.
- Latency:
  - OPC write at edge t0: cmd_count increments after t0.
  - Issue happens at t1 if there is no backpressure; the result is readable at 0x3 after t1.
  - Sustained throughput is 1 command per cycle.
- Ordering: results leave the result FIFO in command-write order; no reordering.
- Simultaneous events on one edge:
  - Push and issue: cmd_count is unchanged.
  - Issue and pop: res_count is unchanged.
  - Full-to-full pass-through is legal in both FIFOs.
- Stickies: set by events, cleared only by a 0x4 write or reset. If clear and set occur on the same edge, set wins.
- Pointers wrap modulo DEPTH. Counts saturate by construction: never above DEPTH, never below 0.
- Reset asserted mid-batch: all queued commands and results are discarded immediately. No partial issue.

Decomposition:
- Shared package noclue_pkg holds:
  - op encodings OP_ADD, OP_SUB, OP_AND, OP_OR;
  - register address constants ADDR_A … ADDR_CNT;
  - status bit indices.
- Sub-module alu_core is purely combinational: inputs a[7:0], b[7:0], op[1:0]; output y[7:0]. It is the same op semantics as the register-mapped ALU and is reusable by it.
- Both FIFOs use one generic sync_fifo instance each, parameterised by width: 18 bits for cmd, 8 bits for result.

Test Plan:
- Single op: reset, write A=0x0F, B=0x01, op=00. Two cycles later 0x3 reads 0x10 and 0x5 reads 0x01. Write 0x3 → status res_empty=1.
- Wrap: A=0x00, B=0x01, op=01 → 0xFF. A=0xFF, B=0x02, op=00 → 0x01.
- Backpressure:
  - Queue 8 ops with no pops → 0x5 reads 0x44, status cmd_full and res_full set, overflow=0.
  - A 9th push sets overflow; the count stays 0x44.
  - Popping all 8 returns results in push order, then 0x5 reads 0x00.
- Pass-through: with both FIFOs full, pop and push 0x2 on the same edge → counts remain 0x44, overflow=0, and the oldest cmd moves to the result FIFO.
- Underflow: after reset, write 0x3 → status bit5=1 and 0x3 reads 0x00. Write 0x4 → bit5=0.
- Async reset: assert rst_n low mid-clock with 3 commands queued → all counts read 0 before the next edge, and status reads 0x05.

Source files
------------

// File: rtl/noclue_pkg.sv
// Shared encodings for the ALU command-queue peripheral: op codes, register map, status bits.
package noclue_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam logic [3:0] ADDR_A    = 4'h0;
  localparam logic [3:0] ADDR_B    = 4'h1;
  localparam logic [3:0] ADDR_OPC  = 4'h2;
  localparam logic [3:0] ADDR_RES  = 4'h3;
  localparam logic [3:0] ADDR_STAT = 4'h4;
  localparam logic [3:0] ADDR_CNT  = 4'h5;

  localparam int ST_CMD_EMPTY = 0;
  localparam int ST_CMD_FULL  = 1;
  localparam int ST_RES_EMPTY = 2;
  localparam int ST_RES_FULL  = 3;
  localparam int ST_OVERFLOW  = 4;
  localparam int ST_UNDERFLOW = 5;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } cmd_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-op 8-bit ALU, results mod 256, no flags; zero latency.
module alu_core
  import noclue_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] op,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    unique case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      default: y = 8'h00;
    endcase
  end

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, head visible combinationally; push-when-full is only legal with a same-edge pop.
// Callers gate push/pop, so the FIFO itself never over- or under-runs.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/tqvp_alu_cmd_queue.sv
// Register-mapped ALU front end: opcode writes queue {A,B,op}; one command per cycle issues into a result FIFO.
// A result is readable one edge after its command is queued; issue stalls only while the result FIFO is full and not popped.
module tqvp_alu_cmd_queue
  import noclue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  logic [7:0]    reg_a, reg_b;
  logic          overflow, underflow;
  cmd_t          cmd_in, cmd_head;
  logic [CW-1:0] cmd_count, res_count;
  logic          cmd_empty, cmd_full, res_empty, res_full;
  logic [7:0]    res_head, alu_y;
  logic          wr_a, wr_b, wr_opc, wr_res, wr_stat;
  logic          res_pop, issue, push_ok, cmd_push;
  logic          unused_ok;

  assign uo_out    = 8'h00;
  assign unused_ok = &{1'b0, ui_in};

  assign wr_a    = data_write && (address == ADDR_A);
  assign wr_b    = data_write && (address == ADDR_B);
  assign wr_opc  = data_write && (address == ADDR_OPC);
  assign wr_res  = data_write && (address == ADDR_RES);
  assign wr_stat = data_write && (address == ADDR_STAT);

  // A pop frees a result slot on the same edge, so a full result FIFO can still accept an issue.
  assign res_pop  = wr_res && !res_empty;
  assign issue    = !cmd_empty && (!res_full || res_pop);
  assign push_ok  = !cmd_full || issue;
  assign cmd_push = wr_opc && push_ok;
  assign cmd_in   = '{a: reg_a, b: reg_b, op: data_in[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a     <= 8'h00;
      reg_b     <= 8'h00;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_a) reg_a <= data_in;
      if (wr_b) reg_b <= data_in;
      // Set has priority over a same-edge clear.
      overflow  <= (overflow  && !wr_stat) || (wr_opc && !push_ok);
      underflow <= (underflow && !wr_stat) || (wr_res && res_empty);
    end
  end

  sync_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH), .CW(CW)) u_cmd_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cmd_push),
    .push_dat (cmd_in),
    .pop      (issue),
    .head     (cmd_head),
    .count    (cmd_count),
    .empty    (cmd_empty),
    .full     (cmd_full)
  );

  alu_core u_alu (
    .a  (cmd_head.a),
    .b  (cmd_head.b),
    .op (cmd_head.op),
    .y  (alu_y)
  );

  sync_fifo #(.W(8), .DEPTH(DEPTH), .CW(CW)) u_res_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (issue),
    .push_dat (alu_y),
    .pop      (res_pop),
    .head     (res_head),
    .count    (res_count),
    .empty    (res_empty),
    .full     (res_full)
  );

  always_comb begin
    data_out = 8'h00;
    unique case (address)
      ADDR_A:    data_out = reg_a;
      ADDR_B:    data_out = reg_b;
      ADDR_OPC:  data_out = cmd_empty ? 8'h00 : {6'b0, cmd_head.op};
      ADDR_RES:  data_out = res_empty ? 8'h00 : res_head;
      ADDR_STAT: begin
        data_out[ST_CMD_EMPTY] = cmd_empty;
        data_out[ST_CMD_FULL]  = cmd_full;
        data_out[ST_RES_EMPTY] = res_empty;
        data_out[ST_RES_FULL]  = res_full;
        data_out[ST_OVERFLOW]  = overflow;
        data_out[ST_UNDERFLOW] = underflow;
      end
      ADDR_CNT:  data_out = {1'b0, cmd_count[2:0], 1'b0, res_count[2:0]};
      default:   data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tqvp_alu_cmd_queue.sv
// Scoreboard bench: reads queue their expected value, a negedge monitor pops and compares.
module tb_tqvp_alu_cmd_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  logic       rd_vld;
  logic [7:0] exp_q[$];
  string      nm_q[$];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  tqvp_alu_cmd_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always @(negedge clk) begin
    logic [7:0] e;
    string      n;
    if (rd_vld) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty: read of addr %0h got %02h with nothing expected", address, data_out);
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (data_out !== e) begin
          fails++;
          $display("FAIL %s: got %02h expected %02h", n, data_out, e);
        end
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(posedge clk);
    #1;
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string nm);
    address    = a;
    data_write = 1'b0;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    rd_vld = 1'b1;
    @(negedge clk);
    #1;
    rd_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] drain_exp [8];
    drain_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h30};

    rst_n = 1'b0; ui_in = 8'h5A; address = 4'h0;
    data_write = 1'b0; data_in = 8'h00; rd_vld = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    rd(4'h4, 8'h05, "reset_status");
    rd(4'h0, 8'h00, "reset_a");
    rd(4'h5, 8'h00, "reset_count");
    rd(4'h3, 8'h00, "reset_result");

    // Single op: 0x0F + 0x01.
    wr(4'h0, 8'h0F); wr(4'h1, 8'h01); wr(4'h2, 8'h00);
    rd(4'h5, 8'h10, "latency_cmd_queued");
    rd(4'h3, 8'h10, "single_add_result");
    rd(4'h5, 8'h01, "single_add_count");
    wr(4'h3, 8'h00);
    rd(4'h4, 8'h05, "single_pop_status");

    wr(4'h0, 8'h00); wr(4'h1, 8'h01); wr(4'h2, 8'h01); idle(1);
    rd(4'h3, 8'hFF, "sub_wrap");
    wr(4'h3, 8'h00);
    wr(4'h0, 8'hFF); wr(4'h1, 8'h02); wr(4'h2, 8'h00); idle(1);
    rd(4'h3, 8'h01, "add_wrap");
    wr(4'h3, 8'h00);

    // Back-to-back AND then OR.
    wr(4'h0, 8'hF0); wr(4'h1, 8'h3C); wr(4'h2, 8'h02);
    rd(4'h2, 8'h02, "op_head_and");
    wr(4'h2, 8'h03); idle(1);
    rd(4'h5, 8'h02, "and_or_count");
    rd(4'h3, 8'h30, "and_result");
    wr(4'h3, 8'h00);
    rd(4'h3, 8'hFC, "or_result");
    wr(4'h3, 8'h00);

    wr(4'h9, 8'hAA);
    rd(4'h0, 8'hF0, "ignored_write_a");
    rd(4'h7, 8'h00, "unmapped_read");
    rd(4'h4, 8'h05, "idle_status");

    // Fill both FIFOs: results 0x10+i; i==3 carries junk in data_in[7:2].
    wr(4'h0, 8'h10);
    for (int i = 0; i < 8; i++) begin
      wr(4'h1, 8'(i));
      wr(4'h2, (i == 3) ? 8'hFC : 8'h00);
    end
    rd(4'h5, 8'h44, "full_count");
    rd(4'h4, 8'h0A, "full_status");
    rd(4'h3, 8'h10, "full_head");
    wr(4'h2, 8'h00);
    rd(4'h5, 8'h44, "overflow_count");
    rd(4'h4, 8'h1A, "overflow_status");
    wr(4'h4, 8'h00);
    rd(4'h4, 8'h0A, "overflow_clear");

    // Pop with both full: the oldest cmd issues on the pop edge.
    wr(4'h3, 8'h00);
    rd(4'h5, 8'h34, "passthru_count");
    rd(4'h4, 8'h08, "passthru_status");
    rd(4'h3, 8'h11, "passthru_order");
    wr(4'h1, 8'h20); wr(4'h2, 8'h00);
    rd(4'h5, 8'h44, "refill_count");
    rd(4'h4, 8'h0A, "refill_status");

    for (int i = 0; i < 8; i++) begin
      rd(4'h3, drain_exp[i], $sformatf("drain_%0d", i));
      wr(4'h3, 8'h00);
    end
    rd(4'h5, 8'h00, "drain_count");
    rd(4'h4, 8'h05, "drain_status");

    wr(4'h3, 8'h00);
    rd(4'h4, 8'h25, "underflow_status");
    rd(4'h3, 8'h00, "underflow_result");
    wr(4'h4, 8'h00);
    rd(4'h4, 8'h05, "underflow_clear");

    // Async reset with work in flight.
    wr(4'h0, 8'h01); wr(4'h1, 8'h01);
    wr(4'h2, 8'h00); wr(4'h2, 8'h00); wr(4'h2, 8'h00);
    rd(4'h5, 8'h12, "pre_reset_count");
    rd(4'h3, 8'h02, "pre_reset_result");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    rd(4'h5, 8'h00, "midreset_count");
    rd(4'h4, 8'h05, "midreset_status");
    rd(4'h0, 8'h00, "midreset_a");
    rst_n = 1'b1;
    idle(2);
    rd(4'h5, 8'h00, "post_reset_count");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
